// File: rtl/reg_wb_sched.sv
// Write-back scheduler: two producers round-robin onto one register file
// write port, plus a 32-entry busy scoreboard for RAW hazard stalls.
module reg_wb_sched #(
  parameter int   DataWidth = 32,
  parameter logic RrInit    = 1'b0
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_a_valid,
  input  logic [4:0]           i_a_reg,
  input  logic [DataWidth-1:0] i_a_data,
  output logic                 o_a_ready,
  input  logic                 i_b_valid,
  input  logic [4:0]           i_b_reg,
  input  logic [DataWidth-1:0] i_b_data,
  output logic                 o_b_ready,
  input  logic                 i_mark_valid,
  input  logic [4:0]           i_mark_reg,
  input  logic                 i_flush,
  output logic [4:0]           o_wreg,
  output logic [DataWidth-1:0] o_wdata,
  output logic                 o_we,
  output logic [31:0]          o_busy,
  output logic                 o_grant_b
);

  logic                 rr;
  logic                 a_win;
  logic                 b_win;
  logic                 xfer;
  logic                 conflict;
  logic [4:0]           xreg;
  logic [DataWidth-1:0] xdata;
  logic [31:0]          busy_nx;

  // rr selects the winner only when both producers request
  always_comb begin
    a_win    = i_a_valid && (!i_b_valid || !rr);
    b_win    = i_b_valid && (!i_a_valid || rr);
    conflict = i_a_valid && i_b_valid;
    xfer     = a_win || b_win;
    xreg     = b_win ? i_b_reg : i_a_reg;
    xdata    = b_win ? i_b_data : i_a_data;
  end

  assign o_a_ready = a_win;
  assign o_b_ready = b_win;

  // mark beats the clear of the same register; flush beats both
  always_comb begin
    busy_nx = o_busy;
    if (xfer)
      busy_nx[xreg] = 1'b0;
    if (i_mark_valid)
      busy_nx[i_mark_reg] = 1'b1;
    if (i_flush)
      busy_nx = '0;
    busy_nx[0] = 1'b0;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rr        <= RrInit;
      o_we      <= 1'b0;
      o_wreg    <= '0;
      o_wdata   <= '0;
      o_busy    <= '0;
      o_grant_b <= 1'b0;
    end else begin
      if (conflict)
        rr <= ~rr;
      o_we      <= xfer && (xreg != 5'd0);
      o_grant_b <= b_win && (xreg != 5'd0);
      if (xfer && (xreg != 5'd0)) begin
        o_wreg  <= xreg;
        o_wdata <= xdata;
      end
      o_busy <= busy_nx;
    end
  end

endmodule

// File: tb/tb_reg_wb_sched.sv
// Bench for reg_wb_sched: directed plan steps followed by random traffic,
// all checked against a transaction-level model of the scheduler.
module tb_reg_wb_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_valid = 0, b_valid = 0, mark_valid = 0, flush = 0;
  logic [4:0]  a_reg = 0, b_reg = 0, mark_reg = 0;
  logic [31:0] a_data = 0, b_data = 0;
  logic        a_ready, b_ready, we, grant_b;
  logic [4:0]  wreg;
  logic [31:0] wdata, busy;

  int passes = 0;
  int total  = 0;

  // model state
  bit          m_pri_b;
  logic [31:0] m_busy;
  bit          m_we, m_gb;
  logic [4:0]  m_wreg;
  logic [31:0] m_wdata;

  always #5 clk = ~clk;

  reg_wb_sched #(.DataWidth(32), .RrInit(1'b0)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_a_valid(a_valid), .i_a_reg(a_reg), .i_a_data(a_data),
    .o_a_ready(a_ready),
    .i_b_valid(b_valid), .i_b_reg(b_reg), .i_b_data(b_data),
    .o_b_ready(b_ready),
    .i_mark_valid(mark_valid), .i_mark_reg(mark_reg), .i_flush(flush),
    .o_wreg(wreg), .o_wdata(wdata), .o_we(we),
    .o_busy(busy), .o_grant_b(grant_b)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    assert (got === exp) passes++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_pri_b = 1'b0;
    m_busy  = '0;
    m_we    = 0;
    m_gb    = 0;
    m_wreg  = '0;
    m_wdata = '0;
  endtask

  task automatic check_outs(input string tag);
    chk({tag, ".we"}, we, m_we);
    chk({tag, ".busy"}, busy, m_busy);
    chk({tag, ".wreg"}, wreg, m_wreg);
    chk({tag, ".wdata"}, wdata, m_wdata);
    if (m_we)
      chk({tag, ".grant_b"}, grant_b, m_gb);
  endtask

  // one clock: drive, check readies, advance model, check outputs
  task automatic step(input string tag,
                      input bit av, input logic [4:0] ar, input logic [31:0] ad,
                      input bit bv, input logic [4:0] br, input logic [31:0] bd,
                      input bit mv, input logic [4:0] mr, input bit fl,
                      output bit a_acc, output bit b_acc);
    bit          w_a, w_b;
    logic [4:0]  r;
    @(negedge clk);
    a_valid = av; a_reg = ar; a_data = ad;
    b_valid = bv; b_reg = br; b_data = bd;
    mark_valid = mv; mark_reg = mr; flush = fl;
    w_a = 0; w_b = 0;
    if (av && bv) begin
      if (m_pri_b) w_b = 1; else w_a = 1;
      m_pri_b = w_a;
    end else begin
      w_a = av;
      w_b = bv;
    end
    #1;
    chk({tag, ".a_ready"}, a_ready, w_a);
    chk({tag, ".b_ready"}, b_ready, w_b);
    r = w_b ? br : ar;
    m_we = 0;
    m_gb = 0;
    if ((w_a || w_b) && r != 0) begin
      m_we    = 1;
      m_gb    = w_b;
      m_wreg  = r;
      m_wdata = w_b ? bd : ad;
    end
    if (w_a || w_b) m_busy[r] = 1'b0;
    if (mv) m_busy[mr] = 1'b1;
    if (fl) m_busy = '0;
    m_busy[0] = 1'b0;
    @(posedge clk);
    #1;
    check_outs(tag);
    a_acc = w_a;
    b_acc = w_b;
  endtask

  task automatic idle(input string tag);
    bit x, y;
    step(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0, x, y);
  endtask

  initial begin
    bit          aa, ba;
    bit          pa, pb;
    logic [4:0]  ra, rb;
    logic [31:0] da, db;

    model_reset();
    #12;
    check_outs("reset");
    @(negedge clk);
    rst = 0;

    // mark then write r5
    step("mark5", 0, 0, 0, 0, 0, 0, 1, 5, 0, aa, ba);
    chk("busy_r5", busy, 32'h0000_0020);
    step("a_r5", 1, 5, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, aa, ba);
    chk("wdata_r5", wdata, 32'hDEAD_BEEF);

    // reset so the pointer is back at A for the conflict run
    @(negedge clk); rst = 1; model_reset();
    @(negedge clk); rst = 0;
    for (int i = 0; i < 4; i++)
      step("conflict", 1, 1, 32'h100 + i, 1, 2, 32'h200 + i,
           0, 0, 0, aa, ba);

    for (int i = 0; i < 3; i++)
      step("b_solo", 0, 0, 0, 1, 4, 32'h40 + i, 0, 0, 0, aa, ba);
    step("both_after_solo", 1, 6, 32'h66, 1, 4, 32'h44, 0, 0, 0, aa, ba);
    chk("a_won_after_solo", aa, 1);

    step("mark3", 0, 0, 0, 0, 0, 0, 1, 3, 0, aa, ba);
    step("b_r0", 0, 0, 0, 1, 0, 32'h1234, 0, 0, 0, aa, ba);
    step("mark7_xfer7", 1, 7, 32'h77, 0, 0, 0, 1, 7, 0, aa, ba);
    chk("busy7_set", busy[7], 1'b1);
    step("flush_mark9", 0, 0, 0, 0, 0, 0, 1, 9, 1, aa, ba);
    chk("flush_clear", busy, 32'h0);

    // async reset while A waits on r3 with a write in flight
    step("mark3b", 0, 0, 0, 0, 0, 0, 1, 3, 0, aa, ba);
    step("a_r8", 1, 8, 32'h88, 0, 0, 0, 0, 0, 0, aa, ba);
    @(negedge clk);
    a_valid = 1; a_reg = 3; a_data = 32'h33;
    #2 rst = 1;
    #1;
    chk("async_we", we, 0);
    chk("async_busy", busy, 0);
    model_reset();
    @(negedge clk); rst = 0;
    step("after_rst_a_r3", 1, 3, 32'h33, 0, 0, 0, 0, 0, 0, aa, ba);
    chk("after_rst_wreg", wreg, 5'd3);

    // random traffic, producers hold their request until accepted
    pa = 0; pb = 0; ra = 0; rb = 0; da = 0; db = 0;
    for (int i = 0; i < 400; i++) begin
      if (!pa) begin
        pa = ($urandom_range(0, 2) != 0);
        ra = 5'($urandom_range(0, 7));
        da = $urandom;
      end
      if (!pb) begin
        pb = ($urandom_range(0, 2) != 0);
        rb = 5'($urandom_range(0, 7));
        db = $urandom;
      end
      step("rand", pa, ra, da, pb, rb, db,
           ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)),
           ($urandom_range(0, 15) == 0), aa, ba);
      if (aa) pa = 0;
      if (ba) pb = 0;
    end
    idle("drain");

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/reg_wb_sched.md
Name: reg_wb_sched

Overview:
- Write-back scheduler for the register file's single write port.
- Arbitrates between two producers: A = execute/ALU result, B = load/memory result. Drives the register file write port (wreg/wdata/we) from a registered output stage.
- Keeps a 32-entry busy scoreboard of destination registers with an outstanding write. Issue logic uses it to stall on RAW hazards.
- Sits between the pipeline back-end and the register file.

Parameters:
- DataWidth, 32, width of write data; must match the register file.
- RrInit, 1'b0, initial round-robin pointer after reset (0 = A has priority first).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_a_valid  in  1  producer A has a write pending.
- i_a_reg  in  5  producer A destination register.
- i_a_data  in  DataWidth  producer A write data.
- o_a_ready  out  1  producer A write accepted this cycle.
- i_b_valid  in  1  producer B has a write pending.
- i_b_reg  in  5  producer B destination register.
- i_b_data  in  DataWidth  producer B write data.
- o_b_ready  out  1  producer B write accepted this cycle.
- i_mark_valid  in  1  issue stage allocates a destination register.
- i_mark_reg  in  5  register to mark busy.
- i_flush  in  1  pipeline flush: clear scoreboard.
- o_wreg  out  5  register file write address.
- o_wdata  out  DataWidth  register file write data.
- o_we  out  1  register file write enable.
- o_busy  out  32  scoreboard; bit n = register n has a pending write.
- o_grant_b  out  1  registered: the current o_we cycle came from B (debug/coverage).

Behaviour:
- Reset (i_rst=1, async): o_we=0, o_wreg=0, o_wdata=0, o_busy=0, o_grant_b=0, rr pointer=RrInit. Asserting reset mid-stream drops any granted-but-unwritten transfer.
- Handshake: a transfer on a producer port occurs when valid && ready. Ready is combinational from the valids and the rr pointer. It never depends on its own port's data.
- Producers must hold valid/reg/data stable until ready. Ready never asserts without the matching valid.
- Arbitration:
  - Only A valid: A granted.
  - Only B valid: B granted.
  - Both valid: grant the side the rr pointer selects (0=A, 1=B).
  - The rr pointer is updated only on a both-valid conflict, and points to the loser. Single requests leave it unchanged.
  - At most one ready is high per cycle.
- Output stage: one cycle latency, registered. A transfer at edge k drives o_we=1, o_wreg, o_wdata during cycle k+1. With no transfer, o_we=0 and o_wreg/o_wdata hold their previous values.
- Register x0: a transfer with reg=0 is accepted (ready=1) but produces o_we=0.
- Throughput: one write per cycle sustained. No backpressure from the register file.
- Scoreboard:
  - On a transfer with reg r≠0, busy[r] clears at the same edge.
  - i_mark_valid with i_mark_reg r≠0 sets busy[r] at the edge. Marks of r=0 are ignored; o_busy[0] is constant 0.
  - Set and clear of the same r in the same cycle: set wins (new producer outstanding).
  - i_flush=1 clears all busy bits at the edge and overrides a simultaneous mark. It does not cancel a transfer or an o_we already in flight.
- Both producers targeting the same register: each is serialized by arbitration; the later grant's data wins in the register file. Any transfer to r clears busy[r]; there is no per-producer tagging.
- Must not create combinational paths from o_we/o_wreg back to ready.

Test Plan:
- Reset → o_we=0, o_busy=0. Mark r5 → o_busy=0x0000_0020. A writes r5=0xDEAD_BEEF → next cycle o_we=1, o_wreg=5, o_wdata=0xDEADBEEF, busy[5]=0.
- A and B both valid for 4 cycles (A→r1, B→r2 held) after reset with RrInit=0 → grants A, B, A, B; o_grant_b=0, 1, 0, 1 one cycle later.
- Only B valid 3 cycles, then A and B valid → B granted 3×, then A (pointer unchanged by solo grants).
- B writes r0 data 0x1234 → o_b_ready=1, next cycle o_we=0; o_busy unchanged.
- Mark r7 and transfer A→r7 in the same cycle → busy[7]=1 after the edge. Flush plus mark r9 in the same cycle → o_busy=0.
- Assert i_rst for 1 cycle while A holds valid on r3 with busy[3]=1 → o_we=0 and o_busy=0 immediately (async). After release A is granted again and writes r3.
